// File: rtl/alu_pkg.sv
// Shared opcode, writeback-target and FSM encodings for the 8-bit execute stage.
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [1:0] DST_NONE = 2'b00;
    localparam logic [1:0] DST_A    = 2'b01;
    localparam logic [1:0] DST_B    = 2'b10;
    localparam logic [1:0] DST_BOTH = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/mul8_seq.sv
// Sequential 8x8 shift-add multiplier; one partial product is accumulated per step.
module mul8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [7:0]  mcand_i,
    input  logic [7:0]  mplier_i,
    output logic [15:0] product_o
);

    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [15:0] acc_q;
    logic [15:0] addend;

    // product_o includes the partial product of the step in progress, so it holds
    // the full product during the eighth step and the caller can write it back then.
    assign addend    = mplier_q[0] ? mcand_q : 16'd0;
    assign product_o = acc_q + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {8'd0, mcand_i};
            mplier_q <= mplier_i;
            acc_q    <= '0;
        end else if (step_i) begin
            acc_q    <= product_o;
            mcand_q  <= {mcand_q[14:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[7:1]};
        end
    end

endmodule

// File: rtl/alu_exec.sv
// 8-bit execute stage: single-cycle logic/arithmetic ops plus an 8-step multiply,
// with registered result, status flags and two architectural registers.
module alu_exec
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] op_i,
    input  logic [1:0] dst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] result_o,
    output logic [7:0] reg_a_o,
    output logic [7:0] reg_b_o,
    output logic       flag_z_o,
    output logic       flag_n_o,
    output logic       flag_c_o,
    output logic       flag_v_o
);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [1:0]  dst_q;
    logic        busy_q, done_q;
    logic [7:0]  result_q, reg_a_q, reg_b_q;
    logic        z_q, n_q, c_q, v_q;

    logic        accept, mul_load, mul_step, mul_last;
    logic [15:0] product;
    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_c, alu_v;
    logic        wb_valid, wb_c, wb_v;
    logic [7:0]  wb_res;
    logic [1:0]  wb_dst;

    assign accept   = (state_q == ST_IDLE) && start_i;
    assign mul_load = accept && (op_i == OP_MUL);
    assign mul_step = (state_q == ST_MUL);
    assign mul_last = mul_step && (cnt_q == 3'd7);

    mul8_seq u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (a_i),
        .mplier_i  (b_i),
        .product_o (product)
    );

    always_comb begin
        sum9    = '0;
        alu_res = a_i;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum9    = {1'b0, a_i} + {1'b0, b_i};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (a_i[7] == b_i[7]) && (sum9[7] != a_i[7]);
            end
            // Bit 8 of the 9-bit difference is the unsigned borrow (a < b).
            OP_SUB: begin
                sum9    = {1'b0, a_i} - {1'b0, b_i};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (a_i[7] != b_i[7]) && (sum9[7] != a_i[7]);
            end
            OP_AND: alu_res = a_i & b_i;
            OP_OR:  alu_res = a_i | b_i;
            OP_XOR: alu_res = a_i ^ b_i;
            OP_NOT: alu_res = ~a_i;
            OP_SHL: begin
                alu_res = {a_i[6:0], 1'b0};
                alu_c   = a_i[7];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_i[7:1]};
                alu_c   = a_i[0];
            end
            default: alu_res = a_i;
        endcase
    end

    always_comb begin
        wb_valid = 1'b0;
        wb_res   = alu_res;
        wb_c     = alu_c;
        wb_v     = alu_v;
        wb_dst   = dst_i;
        if (accept && (op_i != OP_MUL)) begin
            wb_valid = 1'b1;
        end else if (mul_last) begin
            wb_valid = 1'b1;
            wb_res   = product[7:0];
            wb_c     = |product[15:8];
            wb_v     = 1'b0;
            wb_dst   = dst_q;
        end
    end

    // done follows every writeback by one register stage; busy covers the 8 steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dst_q    <= DST_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            done_q <= wb_valid;
            case (state_q)
                ST_IDLE: begin
                    if (mul_load) begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        dst_q   <= dst_i;
                    end
                end
                ST_MUL: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (mul_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (wb_valid) begin
                result_q <= wb_res;
                z_q      <= (wb_res == 8'd0);
                n_q      <= wb_res[7];
                c_q      <= wb_c;
                v_q      <= wb_v;
                if (wb_dst[0]) reg_a_q <= wb_res;
                if (wb_dst[1]) reg_b_q <= wb_res;
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign reg_a_o  = reg_a_q;
    assign reg_b_o  = reg_b_q;
    assign flag_z_o = z_q;
    assign flag_n_o = n_q;
    assign flag_c_o = c_q;
    assign flag_v_o = v_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases, randomized ops against an
// arithmetic reference model, back-to-back issue and reset during multiply.
module tb_alu_exec;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_i, b_i;
    logic [3:0] op_i;
    logic [1:0] dst_i;
    logic       start_i;
    logic       busy_o, done_o;
    logic [7:0] result_o, reg_a_o, reg_b_o;
    logic       flag_z_o, flag_n_o, flag_c_o, flag_v_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mRes, mRa, mRb;
    logic       mZ, mN, mC, mV;

    alu_exec dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_i     (op_i),
        .dst_i    (dst_i),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .reg_a_o  (reg_a_o),
        .reg_b_o  (reg_b_o),
        .flag_z_o (flag_z_o),
        .flag_n_o (flag_n_o),
        .flag_c_o (flag_c_o),
        .flag_v_o (flag_v_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    task automatic modelOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [1:0] dst);
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        mC = 1'b0;
        mV = 1'b0;
        case (op)
            OP_ADD: begin r = ua + ub; mC = (r > 255); sr = sa + sb; mV = (sr > 127) || (sr < -128); end
            OP_SUB: begin r = ua - ub; mC = (ua < ub); sr = sa - sb; mV = (sr > 127) || (sr < -128); end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOT: r = 255 - ua;
            OP_SHL: begin r = ua * 2; mC = (ua >= 128); end
            OP_SHR: begin r = ua / 2; mC = (ua % 2) == 1; end
            OP_MUL: begin r = ua * ub; mC = (r >= 256); end
            default: r = ua;
        endcase
        r    = ((r % 256) + 256) % 256;
        mRes = r[7:0];
        mZ   = (r == 0);
        mN   = (r >= 128);
        if (dst == DST_A || dst == DST_BOTH) mRa = mRes;
        if (dst == DST_B || dst == DST_BOTH) mRb = mRes;
    endtask

    // Drives one request, lets the accepting edge pass, then scrambles the operands.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [1:0] dst);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        dst_i   = dst;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = 4'($urandom);
        a_i     = 8'($urandom);
        b_i     = 8'($urandom);
        dst_i   = 2'($urandom);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_ctrl"},   {14'd0, done_o, busy_o}, 16'b10);
        checkOutput({tag, "_result"}, {8'd0, result_o}, {8'd0, mRes});
        checkOutput({tag, "_rega"},   {8'd0, reg_a_o}, {8'd0, mRa});
        checkOutput({tag, "_regb"},   {8'd0, reg_b_o}, {8'd0, mRb});
        checkOutput({tag, "_flags"},  {12'd0, flag_z_o, flag_n_o, flag_c_o, flag_v_o},
                                      {12'd0, mZ, mN, mC, mV});
    endtask

    // Issues an op and returns at the falling edge inside its done cycle.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] dst, input bit noisy);
        modelOp(op, a, b, dst);
        applyStimulus(op, a, b, dst);
        if (op == OP_MUL) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checkOutput($sformatf("%s_busy%0d", tag, i), {14'd0, done_o, busy_o}, 16'b01);
                if (noisy) begin
                    start_i = 1'($urandom_range(0, 1));
                    op_i    = 4'($urandom);
                    a_i     = 8'($urandom);
                    b_i     = 8'($urandom);
                    dst_i   = 2'($urandom);
                end
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        checkAll(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        op_i    = '0;
        dst_i   = '0;
        mRa = '0; mRb = '0; mRes = '0;
        mZ = 1'b0; mN = 1'b0; mC = 1'b0; mV = 1'b0;

        #1;
        checkOutput("reset_async", {busy_o, done_o, result_o, reg_a_o, flag_z_o, flag_n_o, flag_c_o, flag_v_o},
                    16'd0);
        checkOutput("reset_regb", {8'd0, reg_b_o}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed cases");
        runOp("add7f01", OP_ADD, 8'h7F, 8'h01, DST_A, 1'b0);
        checkOutput("add7f01_const", {reg_a_o, flag_n_o, flag_v_o, flag_c_o, flag_z_o, 4'd0}, {8'h80, 4'b1100, 4'd0});
        @(negedge clk);
        checkOutput("done_single", {15'd0, done_o}, 16'd0);

        runOp("sub0505", OP_SUB, 8'h05, 8'h05, DST_B, 1'b0);
        checkOutput("sub0505_const", {reg_b_o, flag_z_o, flag_c_o, flag_v_o, 5'd0}, {8'h00, 3'b100, 5'd0});
        runOp("sub0305", OP_SUB, 8'h03, 8'h05, DST_NONE, 1'b0);
        checkOutput("sub0305_const", {result_o, flag_c_o, flag_n_o, 6'd0}, {8'hFE, 2'b11, 6'd0});
        @(negedge clk);

        runOp("mul1011", OP_MUL, 8'h10, 8'h11, DST_BOTH, 1'b1);
        checkOutput("mul1011_const", {reg_a_o, reg_b_o}, 16'h1010);
        @(negedge clk);
        checkOutput("mul_no_extra_done", {14'd0, done_o, busy_o}, 16'd0);

        runOp("shl81", OP_SHL, 8'h81, 8'h00, DST_A, 1'b0);
        runOp("shr01_b2b", OP_SHR, 8'h01, 8'h00, DST_B, 1'b0);
        checkOutput("shr01_const", {result_o, flag_c_o, flag_z_o, 6'd0}, {8'h00, 2'b11, 6'd0});
        @(negedge clk);

        $display("[TB] randomized cases");
        for (int n = 0; n < 60; n++) begin
            logic [3:0] rop;
            rop = (n % 5 == 0) ? OP_MUL : 4'($urandom);
            runOp($sformatf("rnd%0d", n), rop, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                checkOutput($sformatf("rnd%0d_idle", n), {14'd0, done_o, busy_o}, 16'd0);
            end
        end

        $display("[TB] reset during multiply");
        applyStimulus(OP_MUL, 8'h10, 8'h11, DST_BOTH);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mulrst_async", {busy_o, done_o, result_o, reg_a_o, flag_z_o, flag_n_o, flag_c_o, flag_v_o},
                    16'd0);
        checkOutput("mulrst_regb", {8'd0, reg_b_o}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mulrst_after%0d", i), {done_o, busy_o, reg_a_o, 6'd0}, 16'd0);
            checkOutput($sformatf("mulrst_regb%0d", i), {8'd0, reg_b_o}, 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: none; datapath fixed at 8 bits to match the MUX A/MUX B operand width.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 a  in  8  operand A, driven by MUX A output.
REQ-005 b  in  8  operand B, driven by MUX B output.
REQ-006 op  in  4  opcode; 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a, 8 MUL, others PASS a.
REQ-007 dst  in  2  writeback target; 00 none, 01 regA, 10 regB, 11 both.
REQ-008 start  in  1  request; sampled only when idle.
REQ-009 busy  out  1  high while a MUL is iterating.
REQ-010 done  out  1  one-cycle pulse; result, flags and registers valid in this cycle.
REQ-011 result  out  8  registered result of last completed operation.
REQ-012 reg_a, reg_b  out  8 each  architectural registers; feed MUX A e0/e1 and MUX B e0.
REQ-013 flag_z, flag_n, flag_c, flag_v  out  1 each  registered status flags.

Function
REQ-014 FSM states IDLE and MUL; IDLE->MUL on start with op=MUL; MUL->IDLE after 8th iteration; all other starts stay in IDLE.
REQ-015 a, b, op, dst latched on the edge that accepts start; later changes to inputs do not affect the operation.
REQ-016 Non-MUL op accepted at edge k: result, flags, destination registers updated at edge k; done=1 for the cycle after edge k.
REQ-017 MUL accepted at edge k: busy=1 from edge k to edge k+8; one shift-add iteration per edge k+1..k+8; writeback at edge k+8; done=1 for the cycle after edge k+8.
REQ-018 start while busy is ignored with no queuing; start in the done cycle is accepted (back-to-back issue).
REQ-019 Arithmetic modulo 256; MUL result is low byte of 16-bit product.
REQ-020 flag_z = (result==0); flag_n = result[7], for every op.
REQ-021 flag_c: ADD carry-out; SUB borrow (a<b unsigned); SHL a[7]; SHR a[0]; MUL high byte nonzero; all others 0.
REQ-022 flag_v: ADD/SUB two's-complement signed overflow; all others 0.
REQ-023 dst=11 writes same result to reg_a and reg_b; dst=00 updates only result and flags.
REQ-024 reg_a/reg_b hold value when not written; flags change only at writeback edges.
REQ-025 done and busy never high simultaneously.

Reset
REQ-026 rst_n low: state IDLE, busy=0, done=0, result=0, reg_a=0, reg_b=0, all flags 0, immediately and without clock.
REQ-027 Reset during MUL aborts it; no writeback and no done pulse after release.
REQ-028 First start is accepted at the first rising edge with rst_n high.

Structure
REQ-029 Shared package alu_pkg holds opcode constants, dst encodings and FSM state encodings; used by alu_exec, control unit and bench.
REQ-030 Multiplier is sub-module mul8_seq (load, step, 8-bit multiplicand/multiplier in, 16-bit product out); all other ops combinational inside alu_exec.

Verification
REQ-031 ADD a=0x7F b=0x01 dst=01 -> done next cycle, reg_a=0x80, N=1 V=1 C=0 Z=0.
REQ-032 SUB a=0x05 b=0x05 dst=10 -> reg_b=0x00, Z=1 C=0 V=0; SUB a=0x03 b=0x05 -> result 0xFE, C=1 N=1.
REQ-033 MUL a=0x10 b=0x11 dst=11 -> busy 8 cycles, done once, reg_a=reg_b=0x10, C=1; start pulses while busy produce no extra done.
REQ-034 Back-to-back: SHL a=0x81 then SHR a=0x01 issued in done cycle -> results 0x02 (C=1), 0x00 (C=1, Z=1), done on consecutive cycles.
REQ-035 rst_n low at MUL iteration 4 -> outputs zero asynchronously; after release no done, reg_a/reg_b remain 0x00.
